// File: rtl/sdram_port_bridge.sv
// Multi-client SDRAM request bridge: per-port strobe edge detection, one-deep
// request slots, round-robin arbitration onto a toggle-handshake SDRAM port.
module sdram_port_bridge #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                            clk_72,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            cpu_cs,
    input  logic [NUM_PORTS-1:0]            cpu_oe,
    input  logic [NUM_PORTS-1:0]            cpu_we,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] cpu_addr,
    input  logic [NUM_PORTS*8-1:0]          cpu_din,
    output logic [NUM_PORTS*8-1:0]          cpu_dout,
    output logic [NUM_PORTS-1:0]            cpu_busy,
    output logic [NUM_PORTS-1:0]            overflow,
    output logic                            sd_req,
    input  logic                            sd_ack,
    output logic [ADDR_WIDTH-2:0]           sd_a,
    output logic [1:0]                      sd_ds,
    output logic                            sd_we,
    output logic [15:0]                     sd_d,
    input  logic [15:0]                     sd_q
);

    localparam int          PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned NP = NUM_PORTS;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [PW-1:0]         grant;
    logic [PW-1:0]         grant_next;
    logic [PW-1:0]         rr_ptr;
    logic                  found;
    int unsigned           idx;

    logic [NUM_PORTS-1:0]  rd_now;
    logic [NUM_PORTS-1:0]  wr_now;
    logic [NUM_PORTS-1:0]  rd_q;
    logic [NUM_PORTS-1:0]  wr_q;
    logic [NUM_PORTS-1:0]  trig;
    logic [ADDR_WIDTH-1:0] addr_now [NUM_PORTS];
    logic [ADDR_WIDTH-1:0] addr_q   [NUM_PORTS];

    logic [NUM_PORTS-1:0]  slot_valid;
    logic [NUM_PORTS-1:0]  slot_we;
    logic [NUM_PORTS-1:0]  slot_clear;
    logic [ADDR_WIDTH-1:0] slot_addr [NUM_PORTS];
    logic [7:0]            slot_din  [NUM_PORTS];

    logic                  cur_lane;
    logic                  ack_match;

    assign ack_match = (sd_ack == sd_req);

    always_comb begin
        rd_now = '0;
        wr_now = '0;
        trig   = '0;
        for (int unsigned p = 0; p < NP; p++) begin
            rd_now[p]   = cpu_cs[p] & cpu_oe[p];
            wr_now[p]   = cpu_cs[p] & cpu_we[p];
            addr_now[p] = cpu_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
            trig[p]     = (rd_now[p] & ~rd_q[p]) | (wr_now[p] & ~wr_q[p]) |
                          (rd_now[p] & (addr_now[p] != addr_q[p]));
        end
    end

    always_comb begin
        cpu_busy = '0;
        for (int unsigned p = 0; p < NP; p++) begin
            cpu_busy[p] = slot_valid[p] | ((state != IDLE) && (grant == PW'(p)));
        end
    end

    always_ff @(posedge clk_72) begin
        if (reset) begin
            state <= IDLE;
            grant <= '0;
        end else begin
            state <= state_next;
            grant <= grant_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_next = grant;
        found      = 1'b0;
        idx        = 0;
        slot_clear = '0;
        case (state)
            IDLE: begin
                // A mismatched ack here is a stale completion; wait it out.
                if (ack_match) begin
                    for (int unsigned i = 1; i <= NP; i++) begin
                        idx = 32'(rr_ptr) + i;
                        if (idx >= NP) idx = idx - NP;
                        if (!found && slot_valid[idx]) begin
                            found      = 1'b1;
                            grant_next = PW'(idx);
                        end
                    end
                    if (found) state_next = ISSUE;
                end
            end
            ISSUE: begin
                slot_clear[grant] = 1'b1;
                state_next        = WAIT;
            end
            WAIT: begin
                if (ack_match) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_72) begin
        if (reset) begin
            rd_q       <= '0;
            wr_q       <= '0;
            slot_valid <= '0;
            slot_we    <= '0;
            overflow   <= '0;
            cpu_dout   <= '0;
            rr_ptr     <= PW'(NUM_PORTS - 1);
            sd_req     <= 1'b0;
            sd_a       <= '0;
            sd_ds      <= '0;
            sd_we      <= 1'b0;
            sd_d       <= '0;
            cur_lane   <= 1'b0;
            for (int unsigned p = 0; p < NP; p++) begin
                addr_q[p]    <= '0;
                slot_addr[p] <= '0;
                slot_din[p]  <= '0;
            end
        end else begin
            rd_q <= rd_now;
            wr_q <= wr_now;
            for (int unsigned p = 0; p < NP; p++) begin
                addr_q[p] <= addr_now[p];
                // A slot being issued this cycle counts as free, so a new trigger loads it.
                if (trig[p]) begin
                    if (!slot_valid[p] || slot_clear[p] || (!slot_we[p] && !wr_now[p])) begin
                        slot_valid[p] <= 1'b1;
                        slot_we[p]    <= wr_now[p];
                        slot_addr[p]  <= addr_now[p];
                        slot_din[p]   <= cpu_din[p*8 +: 8];
                    end else begin
                        overflow[p] <= 1'b1;
                    end
                end else if (slot_clear[p]) begin
                    slot_valid[p] <= 1'b0;
                end
            end

            if (state == ISSUE) begin
                sd_req   <= ~sd_req;
                sd_a     <= slot_addr[grant][ADDR_WIDTH-1:1];
                sd_we    <= slot_we[grant];
                sd_d     <= {slot_din[grant], slot_din[grant]};
                sd_ds    <= slot_we[grant] ? (slot_addr[grant][0] ? 2'b10 : 2'b01) : 2'b11;
                cur_lane <= slot_addr[grant][0];
                rr_ptr   <= grant;
            end

            if ((state == WAIT) && ack_match && !sd_we) begin
                cpu_dout[32'(grant)*8 +: 8] <= cur_lane ? sd_q[15:8] : sd_q[7:0];
            end
        end
    end

endmodule

// File: tb/tb_sdram_port_bridge.sv
// Scoreboard bench for sdram_port_bridge: expected SDRAM requests and per-port
// completions are queued by the stimulus and checked by an independent monitor.
module tb_sdram_port_bridge;

    localparam int LAT = 5;

    logic        clk_72 = 1'b0;
    logic        reset;
    logic [1:0]  cpu_cs;
    logic [1:0]  cpu_oe;
    logic [1:0]  cpu_we;
    logic [31:0] cpu_addr;
    logic [15:0] cpu_din;
    logic [15:0] cpu_dout;
    logic [1:0]  cpu_busy;
    logic [1:0]  overflow;
    logic        sd_req;
    logic        sd_ack;
    logic [14:0] sd_a;
    logic [1:0]  sd_ds;
    logic        sd_we;
    logic [15:0] sd_d;
    logic [15:0] sd_q;

    typedef struct {
        logic [14:0] a;
        logic [1:0]  ds;
        logic        we;
        logic [15:0] d;
    } req_t;

    typedef struct {
        int         port;
        logic [7:0] dout;
    } cpl_t;

    req_t        req_q[$];
    cpl_t        cpl_q[$];
    logic [15:0] rdata_q[$];

    int   checks = 0;
    int   errors = 0;
    logic ctl_en = 1'b1;
    logic ack_force = 1'b0;

    always #5 clk_72 = ~clk_72;

    sdram_port_bridge #(.NUM_PORTS(2), .ADDR_WIDTH(16)) dut (
        .clk_72   (clk_72),
        .reset    (reset),
        .cpu_cs   (cpu_cs),
        .cpu_oe   (cpu_oe),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_din  (cpu_din),
        .cpu_dout (cpu_dout),
        .cpu_busy (cpu_busy),
        .overflow (overflow),
        .sd_req   (sd_req),
        .sd_ack   (sd_ack),
        .sd_a     (sd_a),
        .sd_ds    (sd_ds),
        .sd_we    (sd_we),
        .sd_d     (sd_d),
        .sd_q     (sd_q)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_72);
        #2;
    endtask

    task automatic set_port(input int p, input logic is_wr, input logic [15:0] addr,
                            input logic [7:0] din);
        cpu_cs[p] = 1'b1;
        cpu_oe[p] = ~is_wr;
        cpu_we[p] = is_wr;
        cpu_addr[p*16 +: 16] = addr;
        cpu_din[p*8 +: 8] = din;
    endtask

    task automatic clear_port(input int p);
        cpu_cs[p] = 1'b0;
        cpu_oe[p] = 1'b0;
        cpu_we[p] = 1'b0;
    endtask

    task automatic expect_xfer(input logic [14:0] a, input logic [1:0] ds, input logic we,
                               input logic [15:0] d, input int port, input logic [7:0] dout,
                               input logic [15:0] rdata);
        req_t r;
        cpl_t c;
        r.a = a; r.ds = ds; r.we = we; r.d = d;
        c.port = port; c.dout = dout;
        req_q.push_back(r);
        cpl_q.push_back(c);
        rdata_q.push_back(rdata);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((req_q.size() != 0 || cpl_q.size() != 0 || cpu_busy != 2'b00 ||
                sd_req != sd_ack) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL wait_idle timeout: req_q=%0d cpl_q=%0d busy=%b", req_q.size(),
                     cpl_q.size(), cpu_busy);
        end
    endtask

    // SDRAM controller model: acks LAT cycles after a new toggle request.
    initial begin
        logic [15:0] w;
        sd_ack = 1'b0;
        sd_q   = 16'h0000;
        forever begin
            @(posedge clk_72);
            #1;
            if (!ctl_en) begin
                sd_ack = ack_force;
            end else if (!reset && sd_req != sd_ack) begin
                w = 16'h0000;
                if (rdata_q.size() > 0) w = rdata_q.pop_front();
                repeat (LAT) @(posedge clk_72);
                #1;
                if (ctl_en) begin
                    sd_q   = w;
                    sd_ack = sd_req;
                end
            end
        end
    end

    // Monitor: request toggles and busy falling edges pop the scoreboard.
    initial begin
        logic       prev_req;
        logic [1:0] prev_busy;
        req_t       r;
        cpl_t       c;
        prev_req  = 1'b0;
        prev_busy = 2'b00;
        forever begin
            @(negedge clk_72);
            if (!reset) begin
                if (sd_req != prev_req) begin
                    if (req_q.size() == 0) begin
                        chk("unexpected_request", 32'(sd_a), 32'h0);
                    end else begin
                        r = req_q.pop_front();
                        chk("sd_a", 32'(sd_a), 32'(r.a));
                        chk("sd_ds", 32'(sd_ds), 32'(r.ds));
                        chk("sd_we", 32'(sd_we), 32'(r.we));
                        chk("sd_d", 32'(sd_d), 32'(r.d));
                    end
                end
                for (int p = 0; p < 2; p++) begin
                    if (prev_busy[p] && !cpu_busy[p]) begin
                        if (cpl_q.size() == 0) begin
                            chk("unexpected_completion", 32'(p), 32'hFFFF_FFFF);
                        end else begin
                            c = cpl_q.pop_front();
                            chk("cpl_port", 32'(p), 32'(c.port));
                            chk("cpu_dout", 32'(cpu_dout[p*8 +: 8]), 32'(c.dout));
                        end
                    end
                end
            end
            prev_req  = sd_req;
            prev_busy = cpu_busy;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b1;
        cpu_cs   = '0;
        cpu_oe   = '0;
        cpu_we   = '0;
        cpu_addr = '0;
        cpu_din  = '0;
        repeat (3) tick();
        chk("rst_sd_req", 32'(sd_req), 32'h0);
        chk("rst_sd_we", 32'(sd_we), 32'h0);
        chk("rst_sd_ds", 32'(sd_ds), 32'h0);
        chk("rst_sd_a", 32'(sd_a), 32'h0);
        chk("rst_sd_d", 32'(sd_d), 32'h0);
        chk("rst_cpu_dout", 32'(cpu_dout), 32'h0);
        chk("rst_cpu_busy", 32'(cpu_busy), 32'h0);
        chk("rst_overflow", 32'(overflow), 32'h0);
        reset = 1'b0;
        tick();

        // Single read, odd address -> high byte.
        expect_xfer(15'h091A, 2'b11, 1'b0, 16'h0000, 0, 8'hA5, 16'hA55A);
        set_port(0, 1'b0, 16'h1235, 8'h00);
        tick();
        clear_port(0);
        wait_idle();

        // Write byte lanes on port 1; dout untouched.
        expect_xfer(15'h0020, 2'b01, 1'b1, 16'h3C3C, 1, 8'h00, 16'hFFFF);
        set_port(1, 1'b1, 16'h0040, 8'h3C);
        tick();
        clear_port(1);
        wait_idle();
        expect_xfer(15'h0020, 2'b10, 1'b1, 16'h3C3C, 1, 8'h00, 16'hFFFF);
        set_port(1, 1'b1, 16'h0041, 8'h3C);
        tick();
        clear_port(1);
        wait_idle();

        // Round-robin: two simultaneous pairs, each served 0 then 1.
        expect_xfer(15'h0080, 2'b11, 1'b0, 16'h0000, 0, 8'h22, 16'h1122);
        expect_xfer(15'h0101, 2'b11, 1'b0, 16'h0000, 1, 8'h33, 16'h3344);
        set_port(0, 1'b0, 16'h0100, 8'h00);
        set_port(1, 1'b0, 16'h0203, 8'h00);
        tick();
        clear_port(0);
        clear_port(1);
        wait_idle();
        expect_xfer(15'h0182, 2'b11, 1'b0, 16'h0000, 0, 8'h55, 16'h5566);
        expect_xfer(15'h0200, 2'b11, 1'b0, 16'h0000, 1, 8'h88, 16'h7788);
        set_port(0, 1'b0, 16'h0305, 8'h00);
        set_port(1, 1'b0, 16'h0400, 8'h00);
        tick();
        clear_port(0);
        clear_port(1);
        wait_idle();

        // Read coalescing on port 0 while port 1 is in WAIT.
        expect_xfer(15'h0280, 2'b11, 1'b0, 16'h0000, 1, 8'hAA, 16'h99AA);
        expect_xfer(15'h0010, 2'b11, 1'b0, 16'h0000, 0, 8'hCC, 16'hBBCC);
        set_port(1, 1'b0, 16'h0500, 8'h00);
        tick();
        clear_port(1);
        tick();
        tick();
        set_port(0, 1'b0, 16'h0010, 8'h00);
        tick();
        set_port(0, 1'b0, 16'h0020, 8'h00);
        tick();
        clear_port(0);
        wait_idle();
        chk("overflow_after_coalesce", 32'(overflow), 32'h0);

        // Write then a second write before issue: second dropped.
        expect_xfer(15'h0300, 2'b11, 1'b0, 16'h0000, 1, 8'hEE, 16'hDDEE);
        expect_xfer(15'h0018, 2'b01, 1'b1, 16'h1111, 0, 8'hCC, 16'h0000);
        set_port(1, 1'b0, 16'h0600, 8'h00);
        tick();
        clear_port(1);
        tick();
        tick();
        set_port(0, 1'b1, 16'h0030, 8'h11);
        tick();
        clear_port(0);
        tick();
        set_port(0, 1'b1, 16'h0032, 8'h22);
        tick();
        clear_port(0);
        wait_idle();
        chk("overflow_after_drop", 32'(overflow), 32'h1);

        // Reset while a read is in WAIT.
        expect_xfer(15'h0380, 2'b11, 1'b0, 16'h0000, 0, 8'h00, 16'h0000);
        set_port(0, 1'b0, 16'h0700, 8'h00);
        tick();
        clear_port(0);
        tick();
        tick();
        ctl_en    = 1'b0;
        ack_force = 1'b1;
        reset     = 1'b1;
        tick();
        tick();
        chk("midrst_sd_req", 32'(sd_req), 32'h0);
        chk("midrst_busy", 32'(cpu_busy), 32'h0);
        chk("midrst_overflow", 32'(overflow), 32'h0);
        reset = 1'b0;
        req_q.delete();
        cpl_q.delete();
        rdata_q.delete();
        tick();
        set_port(1, 1'b0, 16'h0800, 8'h00);
        tick();
        clear_port(1);
        repeat (6) tick();
        chk("stale_ack_sd_req", 32'(sd_req), 32'h0);
        chk("stale_ack_busy", 32'(cpu_busy), 32'h2);
        expect_xfer(15'h0400, 2'b11, 1'b0, 16'h0000, 1, 8'h57, 16'h1357);
        ack_force = 1'b0;
        tick();
        tick();
        ctl_en = 1'b1;
        wait_idle();
        chk("final_dout", 32'(cpu_dout), 32'h5700);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
